// File: rtl/sram_cache_burst.sv
// Direct-mapped write-back/write-allocate cache between a CPU slave bus and an SRAM command port.
// Lines move as bursts of single-word memory transactions; a host flush writes back and invalidates everything.
module sram_cache_burst #(
    parameter int ADDR_W     = 17,
    parameter int INDEX_W    = 9,
    parameter int WORDS_LOG2 = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] s_addr,
    input  logic [31:0]       s_wrdata,
    input  logic [3:0]        s_bytesel,
    input  logic              s_wren,
    input  logic              s_strobe,
    output logic              s_wait,
    output logic [31:0]       s_rddata,
    input  logic              flush_req,
    output logic              busy,
    output logic [ADDR_W-1:0] m_addr,
    output logic [31:0]       m_wrdata,
    output logic              m_wren,
    output logic              m_strobe,
    input  logic              m_wait,
    input  logic [31:0]       m_rddata
);
    localparam int TAG_W  = ADDR_W - INDEX_W - WORDS_LOG2;
    localparam int LINE_W = INDEX_W + WORDS_LOG2;
    localparam int TE_W   = TAG_W + 2;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_IDLE  = 3'd1,
        ST_CHECK = 3'd2,
        ST_WB    = 3'd3,
        ST_FILL  = 3'd4,
        ST_FSCAN = 3'd5,
        ST_FWB   = 3'd6
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [WORDS_LOG2-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [INDEX_W-1:0]    r_idx, w_idx_nxt, w_burst_idx;
    logic                  r_m_strobe, w_mstrobe_nxt;
    logic                  r_m_wren, w_mwren_nxt;
    logic [ADDR_W-1:0]     r_m_addr, w_maddr_nxt;
    logic [31:0]           r_ram_q;
    logic [31:0]           r_data_mem [0:(1<<LINE_W)-1];
    logic [TE_W-1:0]       r_tag_mem  [0:(1<<INDEX_W)-1];

    logic [WORDS_LOG2-1:0] w_s_word;
    logic [INDEX_W-1:0]    w_s_idx;
    logic [TAG_W-1:0]      w_s_tag;
    logic [TE_W-1:0]       w_vic, w_scan;
    logic                  w_hit, w_acc, w_last;
    logic [LINE_W-1:0]     w_ram_raddr, w_ram_waddr;
    logic                  w_ram_we;
    logic [31:0]           w_ram_wdata;
    logic [3:0]            w_ram_be;
    logic                  w_tag_we;
    logic [INDEX_W-1:0]    w_tag_waddr;
    logic [TE_W-1:0]       w_tag_wdata;
    logic                  w_s_wait;

    assign w_s_word    = s_addr[WORDS_LOG2-1:0];
    assign w_s_idx     = s_addr[WORDS_LOG2 +: INDEX_W];
    assign w_s_tag     = s_addr[ADDR_W-1 -: TAG_W];
    assign w_vic       = r_tag_mem[w_s_idx];
    assign w_scan      = r_tag_mem[r_idx];
    assign w_hit       = w_vic[TE_W-1] && (w_vic[TAG_W-1:0] == w_s_tag);
    assign w_acc       = r_m_strobe && !m_wait;
    assign w_last      = (r_cnt == {WORDS_LOG2{1'b1}});
    assign w_cnt_inc   = r_cnt + WORDS_LOG2'(1);
    assign w_burst_idx = (r_state == ST_FWB) ? r_idx : w_s_idx;

    assign s_wait   = w_s_wait;
    assign s_rddata = r_ram_q;
    assign m_wrdata = r_ram_q;
    assign m_addr   = r_m_addr;
    assign m_wren   = r_m_wren;
    assign m_strobe = r_m_strobe;
    assign busy     = (r_state == ST_INIT) || (r_state == ST_FSCAN) || (r_state == ST_FWB);

    // Next-state, burst sequencing and RAM/tag port control
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_idx_nxt     = r_idx;
        w_mstrobe_nxt = r_m_strobe;
        w_mwren_nxt   = r_m_wren;
        w_maddr_nxt   = r_m_addr;
        w_ram_raddr   = {w_s_idx, w_s_word};
        w_ram_waddr   = {w_s_idx, w_s_word};
        w_ram_we      = 1'b0;
        w_ram_wdata   = s_wrdata;
        w_ram_be      = s_bytesel;
        w_tag_we      = 1'b0;
        w_tag_waddr   = w_s_idx;
        w_tag_wdata   = {TE_W{1'b0}};
        w_s_wait      = 1'b1;
        case (r_state)
            ST_INIT: begin
                w_tag_we    = 1'b1;
                w_tag_waddr = r_idx;
                if (r_idx == {INDEX_W{1'b1}}) begin
                    w_state_nxt = ST_IDLE;
                    w_idx_nxt   = {INDEX_W{1'b0}};
                end else begin
                    w_idx_nxt = r_idx + INDEX_W'(1);
                end
            end
            ST_IDLE: begin
                if (flush_req) begin
                    w_state_nxt = ST_FSCAN;
                    w_idx_nxt   = {INDEX_W{1'b0}};
                end else if (s_strobe) begin
                    w_state_nxt = ST_CHECK;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_CHECK: begin
                w_cnt_nxt = {WORDS_LOG2{1'b0}};
                if (w_hit) begin
                    w_s_wait    = 1'b0;
                    w_state_nxt = ST_IDLE;
                    if (s_wren) begin
                        w_ram_we    = 1'b1;
                        w_tag_we    = 1'b1;
                        w_tag_wdata = {1'b1, 1'b1, w_s_tag};
                    end else begin
                        w_ram_we = 1'b0;
                    end
                end else if (w_vic[TE_W-1] && w_vic[TE_W-2]) begin
                    w_state_nxt   = ST_WB;
                    w_ram_raddr   = {w_s_idx, WORDS_LOG2'(0)};
                    w_mstrobe_nxt = 1'b1;
                    w_mwren_nxt   = 1'b1;
                    w_maddr_nxt   = {w_vic[TAG_W-1:0], w_s_idx, WORDS_LOG2'(0)};
                end else begin
                    w_state_nxt   = ST_FILL;
                    w_mstrobe_nxt = 1'b1;
                    w_mwren_nxt   = 1'b0;
                    w_maddr_nxt   = {w_s_tag, w_s_idx, WORDS_LOG2'(0)};
                end
            end
            ST_WB, ST_FWB: begin
                // Present the next word on acceptance so the burst runs without bubbles
                w_ram_raddr = {w_burst_idx, r_cnt};
                if (w_acc) begin
                    w_ram_raddr = {w_burst_idx, w_cnt_inc};
                    w_cnt_nxt   = w_cnt_inc;
                    w_maddr_nxt = {r_m_addr[ADDR_W-1:WORDS_LOG2], w_cnt_inc};
                    if (w_last && (r_state == ST_WB)) begin
                        w_state_nxt = ST_FILL;
                        w_mwren_nxt = 1'b0;
                        w_maddr_nxt = {w_s_tag, w_s_idx, WORDS_LOG2'(0)};
                    end else if (w_last) begin
                        w_state_nxt   = ST_FSCAN;
                        w_mstrobe_nxt = 1'b0;
                        w_mwren_nxt   = 1'b0;
                        w_tag_we      = 1'b1;
                        w_tag_waddr   = r_idx;
                    end else begin
                        w_state_nxt = r_state;
                    end
                end else begin
                    w_cnt_nxt = r_cnt;
                end
            end
            ST_FILL: begin
                if (w_acc) begin
                    w_ram_we    = 1'b1;
                    w_ram_waddr = {w_s_idx, r_cnt};
                    w_ram_wdata = m_rddata;
                    w_ram_be    = 4'hF;
                    w_cnt_nxt   = w_cnt_inc;
                    w_maddr_nxt = {r_m_addr[ADDR_W-1:WORDS_LOG2], w_cnt_inc};
                    if (w_last) begin
                        w_state_nxt   = ST_IDLE;
                        w_mstrobe_nxt = 1'b0;
                        w_maddr_nxt   = r_m_addr;
                        w_tag_we      = 1'b1;
                        w_tag_wdata   = {1'b1, 1'b0, w_s_tag};
                    end else begin
                        w_state_nxt = ST_FILL;
                    end
                end else begin
                    w_ram_we = 1'b0;
                end
            end
            ST_FSCAN: begin
                w_cnt_nxt = {WORDS_LOG2{1'b0}};
                if (w_scan[TE_W-1] && w_scan[TE_W-2]) begin
                    w_state_nxt   = ST_FWB;
                    w_ram_raddr   = {r_idx, WORDS_LOG2'(0)};
                    w_mstrobe_nxt = 1'b1;
                    w_mwren_nxt   = 1'b1;
                    w_maddr_nxt   = {w_scan[TAG_W-1:0], r_idx, WORDS_LOG2'(0)};
                end else begin
                    w_tag_we    = 1'b1;
                    w_tag_waddr = r_idx;
                    if (r_idx == {INDEX_W{1'b1}}) begin
                        w_state_nxt = ST_IDLE;
                        w_idx_nxt   = {INDEX_W{1'b0}};
                    end else begin
                        w_idx_nxt = r_idx + INDEX_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_INIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Counters and registered memory-side command outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt      <= {WORDS_LOG2{1'b0}};
            r_idx      <= {INDEX_W{1'b0}};
            r_m_strobe <= 1'b0;
            r_m_wren   <= 1'b0;
            r_m_addr   <= {ADDR_W{1'b0}};
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_idx      <= w_idx_nxt;
            r_m_strobe <= w_mstrobe_nxt;
            r_m_wren   <= w_mwren_nxt;
            r_m_addr   <= w_maddr_nxt;
        end
    end

    // Byte-writable data RAM with one-cycle registered read
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_ram_be[b]) begin
                    r_data_mem[w_ram_waddr][8*b +: 8] <= w_ram_wdata[8*b +: 8];
                end
            end
        end
        r_ram_q <= r_data_mem[w_ram_raddr];
    end

    // Tag RAM write port
    always_ff @(posedge clk) begin
        if (w_tag_we) begin
            r_tag_mem[w_tag_waddr] <= w_tag_wdata;
        end
    end
endmodule

// File: tb/tb_sram_cache_burst.sv
// Directed self-checking bench for sram_cache_burst with a stallable memory model and transaction log.
module tb_sram_cache_burst;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [16:0] s_addr = 17'h0;
    logic [31:0] s_wrdata = 32'h0;
    logic [3:0]  s_bytesel = 4'h0;
    logic        s_wren = 1'b0;
    logic        s_strobe = 1'b0;
    logic        s_wait;
    logic [31:0] s_rddata;
    logic        flush_req = 1'b0;
    logic        busy;
    logic [16:0] m_addr;
    logic [31:0] m_wrdata;
    logic        m_wren;
    logic        m_strobe;
    logic        m_wait = 1'b0;
    logic [31:0] m_rddata;

    logic [31:0] ext_mem [0:(1<<17)-1];
    logic [16:0] log_addr [$];
    logic        log_wren [$];
    logic [31:0] log_data [$];
    int          stall_n = 0;
    int          wcnt = 0;
    bit          held = 1'b0;
    logic [16:0] held_addr;
    logic [31:0] held_data;
    int          stall_viol = 0;
    int          checks = 0;
    int          failures = 0;

    sram_cache_burst dut (
        .clk(clk), .reset_n(reset_n), .s_addr(s_addr), .s_wrdata(s_wrdata),
        .s_bytesel(s_bytesel), .s_wren(s_wren), .s_strobe(s_strobe), .s_wait(s_wait),
        .s_rddata(s_rddata), .flush_req(flush_req), .busy(busy), .m_addr(m_addr),
        .m_wrdata(m_wrdata), .m_wren(m_wren), .m_strobe(m_strobe), .m_wait(m_wait),
        .m_rddata(m_rddata)
    );

    always #5 clk = ~clk;

    assign m_rddata = ext_mem[m_addr];

    // Memory model: decides m_wait for the coming edge and logs each accepted transaction
    always @(negedge clk) begin
        if (m_strobe) begin
            if (held && ((m_addr !== held_addr) || (m_wren && (m_wrdata !== held_data))))
                stall_viol++;
            if (wcnt < stall_n) begin
                m_wait = 1'b1; wcnt++; held = 1'b1; held_addr = m_addr; held_data = m_wrdata;
            end else begin
                m_wait = 1'b0; wcnt = 0; held = 1'b0;
                log_addr.push_back(m_addr); log_wren.push_back(m_wren); log_data.push_back(m_wrdata);
                if (m_wren) ext_mem[m_addr] = m_wrdata;
            end
        end else begin
            m_wait = 1'b0; wcnt = 0; held = 1'b0;
        end
    end

    task automatic clear_log();
        log_addr.delete(); log_wren.delete(); log_data.delete();
    endtask

    task automatic cpu_access(input logic [16:0] a, input logic wr, input logic [31:0] d,
                              input logic [3:0] be, output logic [31:0] rd, output int cyc);
        bit done = 1'b0;
        s_addr = a; s_wren = wr; s_wrdata = d; s_bytesel = be; s_strobe = 1'b1;
        cyc = 0; rd = 32'h0;
        for (int k = 0; k < 3000; k++) begin
            cyc++;
            if (!s_wait) begin rd = s_rddata; done = 1'b1; break; end
            @(negedge clk);
        end
        checks++;
        if (!done) begin failures++; $display("FAIL access_timeout addr=%h got=stuck exp=complete", a); end
        @(negedge clk);
        s_strobe = 1'b0; s_wren = 1'b0;
    endtask

    task automatic wait_init(input string nm);
        int n = 0;
        while (busy && n < 2000) begin @(negedge clk); n++; end
        checks++;
        if (n !== 512) begin failures++; $display("FAIL %s_init_cycles got=%0d exp=512", nm, n); end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++; if (s_wait !== 1'b1)   begin failures++; $display("FAIL rst_s_wait got=%b exp=1", s_wait); end
        checks++; if (busy !== 1'b1)     begin failures++; $display("FAIL rst_busy got=%b exp=1", busy); end
        checks++; if (m_strobe !== 1'b0) begin failures++; $display("FAIL rst_m_strobe got=%b exp=0", m_strobe); end
        checks++; if (m_wren !== 1'b0)   begin failures++; $display("FAIL rst_m_wren got=%b exp=0", m_wren); end
        checks++; if (m_addr !== 17'h0)  begin failures++; $display("FAIL rst_m_addr got=%h exp=0", m_addr); end
        reset_n = 1'b1;
        wait_init("reset");
    endtask

    task automatic test_clean_miss();
        logic [31:0] rd; int cyc;
        clear_log();
        cpu_access(17'h00000, 1'b0, 32'h0, 4'h0, rd, cyc);
        checks++; if (rd !== 32'hC0DE0000) begin failures++; $display("FAIL clean_rd got=%h exp=c0de0000", rd); end
        checks++; if (cyc !== 8) begin failures++; $display("FAIL clean_cycles got=%0d exp=8", cyc); end
        checks++; if (log_addr.size() !== 4) begin failures++; $display("FAIL clean_count got=%0d exp=4", log_addr.size()); end
        for (int i = 0; i < 4 && i < log_addr.size(); i++) begin
            checks++;
            if (log_addr[i] !== 17'(i) || log_wren[i] !== 1'b0) begin
                failures++; $display("FAIL clean_txn%0d got=%h/%b exp=%h/0", i, log_addr[i], log_wren[i], i);
            end
        end
    endtask

    task automatic test_write_hit();
        logic [31:0] rd; int cyc;
        cpu_access(17'h00004, 1'b0, 32'h0, 4'h0, rd, cyc);
        clear_log();
        cpu_access(17'h00005, 1'b1, 32'hDEADBEEF, 4'b0011, rd, cyc);
        checks++; if (cyc !== 2) begin failures++; $display("FAIL hit_wr_cycles got=%0d exp=2", cyc); end
        cpu_access(17'h00005, 1'b0, 32'h0, 4'h0, rd, cyc);
        checks++; if (rd !== 32'hC0DEBEEF) begin failures++; $display("FAIL hit_rd got=%h exp=c0debeef", rd); end
        checks++; if (cyc !== 2) begin failures++; $display("FAIL hit_rd_cycles got=%0d exp=2", cyc); end
        checks++; if (log_addr.size() !== 0) begin failures++; $display("FAIL hit_traffic got=%0d exp=0", log_addr.size()); end
    endtask

    task automatic test_dirty_miss();
        logic [31:0] rd; int cyc;
        logic [31:0] wd [4];
        wd[0] = 32'hC0DE0004; wd[1] = 32'hC0DEBEEF; wd[2] = 32'hC0DE0006; wd[3] = 32'hC0DE0007;
        clear_log();
        cpu_access(17'h00804, 1'b0, 32'h0, 4'h0, rd, cyc);
        checks++; if (rd !== 32'hC0DE0804) begin failures++; $display("FAIL dirty_rd got=%h exp=c0de0804", rd); end
        checks++; if (cyc !== 12) begin failures++; $display("FAIL dirty_cycles got=%0d exp=12", cyc); end
        checks++; if (log_addr.size() !== 8) begin failures++; $display("FAIL dirty_count got=%0d exp=8", log_addr.size()); end
        for (int i = 0; i < 4 && i + 4 < log_addr.size(); i++) begin
            checks++;
            if (log_addr[i] !== 17'(4 + i) || log_wren[i] !== 1'b1 || log_data[i] !== wd[i]) begin
                failures++; $display("FAIL dirty_wb%0d got=%h/%b/%h exp=%h/1/%h", i, log_addr[i], log_wren[i], log_data[i], 4 + i, wd[i]);
            end
            checks++;
            if (log_addr[i+4] !== 17'(12'h804 + i) || log_wren[i+4] !== 1'b0) begin
                failures++; $display("FAIL dirty_fill%0d got=%h/%b exp=%h/0", i, log_addr[i+4], log_wren[i+4], 12'h804 + i);
            end
        end
    endtask

    task automatic test_stall();
        logic [31:0] rd; int cyc;
        logic [16:0] ea [8];
        logic [31:0] wd [4];
        wd[0] = 32'hC0DE0804; wd[1] = 32'hC0DE0805; wd[2] = 32'h12345678; wd[3] = 32'hC0DE0807;
        for (int i = 0; i < 4; i++) begin ea[i] = 17'(12'h804 + i); ea[i+4] = 17'(4 + i); end
        cpu_access(17'h00806, 1'b1, 32'h12345678, 4'hF, rd, cyc);
        clear_log();
        stall_viol = 0;
        stall_n = 3;
        cpu_access(17'h00004, 1'b0, 32'h0, 4'h0, rd, cyc);
        stall_n = 0;
        checks++; if (rd !== 32'hC0DE0004) begin failures++; $display("FAIL stall_rd got=%h exp=c0de0004", rd); end
        checks++; if (cyc !== 36) begin failures++; $display("FAIL stall_cycles got=%0d exp=36", cyc); end
        checks++; if (stall_viol !== 0) begin failures++; $display("FAIL stall_stable got=%0d exp=0", stall_viol); end
        checks++; if (log_addr.size() !== 8) begin failures++; $display("FAIL stall_count got=%0d exp=8", log_addr.size()); end
        for (int i = 0; i < 8 && i < log_addr.size(); i++) begin
            checks++;
            if (log_addr[i] !== ea[i] || log_wren[i] !== (i < 4) || (i < 4 && log_data[i] !== wd[i])) begin
                failures++; $display("FAIL stall_txn%0d got=%h/%b exp=%h/%b", i, log_addr[i], log_wren[i], ea[i], (i < 4));
            end
        end
    endtask

    task automatic test_flush();
        logic [31:0] rd; int cyc; int n;
        logic [16:0] ea [8];
        logic [31:0] wd [8];
        ea[0] = 17'h008; ea[1] = 17'h009; ea[2] = 17'h00A; ea[3] = 17'h00B;
        ea[4] = 17'h7FC; ea[5] = 17'h7FD; ea[6] = 17'h7FE; ea[7] = 17'h7FF;
        wd[0] = 32'h11110000; wd[1] = 32'hC0DE0009; wd[2] = 32'hC0DE000A; wd[3] = 32'hC0DE000B;
        wd[4] = 32'hC0DE07FC; wd[5] = 32'hC0DE07FD; wd[6] = 32'hC0DE07FE; wd[7] = 32'h22220000;
        cpu_access(17'h00008, 1'b1, 32'h11110000, 4'hF, rd, cyc);
        cpu_access(17'h007FF, 1'b1, 32'h22220000, 4'hF, rd, cyc);
        clear_log();
        flush_req = 1'b1;
        @(negedge clk);
        flush_req = 1'b0;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL flush_busy got=%b exp=1", busy); end
        n = 0;
        while (busy && n < 3000) begin @(negedge clk); n++; end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL flush_done got=busy exp=idle"); end
        checks++; if (log_addr.size() !== 8) begin failures++; $display("FAIL flush_count got=%0d exp=8", log_addr.size()); end
        for (int i = 0; i < 8 && i < log_addr.size(); i++) begin
            checks++;
            if (log_addr[i] !== ea[i] || log_wren[i] !== 1'b1 || log_data[i] !== wd[i]) begin
                failures++; $display("FAIL flush_txn%0d got=%h/%b/%h exp=%h/1/%h", i, log_addr[i], log_wren[i], log_data[i], ea[i], wd[i]);
            end
        end
        clear_log();
        cpu_access(17'h00008, 1'b0, 32'h0, 4'h0, rd, cyc);
        checks++; if (rd !== 32'h11110000) begin failures++; $display("FAIL flush_reread got=%h exp=11110000", rd); end
        checks++; if (cyc !== 8 || log_addr.size() !== 4) begin failures++; $display("FAIL flush_refetch got=%0d/%0d exp=8/4", cyc, log_addr.size()); end
        cpu_access(17'h007FF, 1'b0, 32'h0, 4'h0, rd, cyc);
        checks++; if (rd !== 32'h22220000 || cyc !== 8) begin failures++; $display("FAIL flush_reread511 got=%h/%0d exp=22220000/8", rd, cyc); end
    endtask

    task automatic test_reset_mid_fill();
        logic [31:0] rd; int cyc; int n;
        s_addr = 17'h01000; s_wren = 1'b0; s_strobe = 1'b1;
        n = 0;
        while (!m_strobe && n < 50) begin @(negedge clk); n++; end
        @(negedge clk);
        checks++; if (m_strobe !== 1'b1) begin failures++; $display("FAIL midfill_strobe got=%b exp=1", m_strobe); end
        reset_n = 1'b0; s_strobe = 1'b0;
        #1;
        checks++; if (m_strobe !== 1'b0) begin failures++; $display("FAIL midfill_rst_strobe got=%b exp=0", m_strobe); end
        checks++; if (busy !== 1'b1 || s_wait !== 1'b1) begin failures++; $display("FAIL midfill_rst_state got=%b%b exp=11", busy, s_wait); end
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        wait_init("midfill");
        clear_log();
        cpu_access(17'h00000, 1'b0, 32'h0, 4'h0, rd, cyc);
        checks++; if (cyc !== 8 || log_addr.size() !== 4) begin failures++; $display("FAIL midfill_miss got=%0d/%0d exp=8/4", cyc, log_addr.size()); end
        checks++; if (rd !== 32'hC0DE0000) begin failures++; $display("FAIL midfill_rd got=%h exp=c0de0000", rd); end
    endtask

    initial begin
        for (int a = 0; a < (1 << 17); a++) ext_mem[a] = 32'hC0DE0000 | 32'(a);
        test_reset();
        test_clean_miss();
        test_write_hit();
        test_dirty_miss();
        test_stall();
        test_flush();
        test_reset_mid_fill();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
